// File: rtl/regfile_scanner_if.sv
// rtl/regfile_scanner_if.sv - (index, value) pair stream between regfile_scanner and its consumer
interface regfile_scanner_if;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;

    modport master (output out_valid, output out_idx, output out_data, input out_ready);
    modport slave  (input out_valid, input out_idx, input out_data, output out_ready);
endinterface

// File: rtl/regfile_scanner.sv
// rtl/regfile_scanner.sv - walks sccomp reg_sel and streams (index, value) pairs; option SCAN_CHANGE_ONLY_EN
module regfile_scanner #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int SETTLE    = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                cont,
    output logic [4:0]          reg_sel,
    input  logic [31:0]         reg_data,
    regfile_scanner_if.master   pairs,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_OUTPUT, S_NEXT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [4:0]  idx;
    logic [4:0]  out_idx_q;
    logic [31:0] out_data_q;
    logic        last;
    logic        skip;

    assign last = (idx == 5'(LAST_REG));

`ifdef SCAN_CHANGE_ONLY_EN
    logic [31:0] shadow [32];
    logic [31:0] shadow_vld;

    // Unchanged registers since their last emission are not re-sent.
    assign skip = shadow_vld[idx] && (shadow[idx] == reg_data);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_vld <= '0;
        end else if (state == S_OUTPUT && pairs.out_ready) begin
            shadow_vld[out_idx_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_OUTPUT && pairs.out_ready) begin
            shadow[out_idx_q] <= out_data_q;
        end
    end
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_SETTLE;
            S_SETTLE:  if (cnt == 4'd0) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = skip ? S_NEXT : S_OUTPUT;
            S_OUTPUT:  if (pairs.out_ready) state_nxt = S_NEXT;
            S_NEXT:    state_nxt = (!last || cont) ? S_SETTLE : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // idx only moves on the edges that enter SETTLE, so reg_sel is frozen while a pair is offered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx        <= 5'd0;
            cnt        <= 4'd0;
            out_idx_q  <= 5'd0;
            out_data_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx <= 5'(FIRST_REG);
                        cnt <= 4'(SETTLE - 1);
                    end
                end
                S_SETTLE: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                S_CAPTURE: begin
                    if (!skip) begin
                        out_data_q <= reg_data;
                        out_idx_q  <= idx;
                    end
                end
                S_NEXT: begin
                    cnt <= 4'(SETTLE - 1);
                    if (!last) begin
                        idx <= idx + 5'd1;
                    end else if (cont) begin
                        idx <= 5'(FIRST_REG);
                    end
                end
                default: ;
            endcase
        end
    end

    assign reg_sel         = idx;
    assign pairs.out_valid = (state == S_OUTPUT);
    assign pairs.out_idx   = out_idx_q;
    assign pairs.out_data  = out_data_q;
    assign busy            = (state != S_IDLE);
    assign done            = (state == S_NEXT) && last;

endmodule
